// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters drive the decode stall.
// Optional SB_BYPASS_EN: a same-cycle retire of the hazard register lifts the stall.
module reg_scoreboard #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned IDX_W = 5,
   parameter int unsigned NWB   = 2,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned OUT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid_i,
   input  logic [IDX_W-1:0]     issue_rs1_i,
   input  logic                 issue_rs1_use_i,
   input  logic [IDX_W-1:0]     issue_rs2_i,
   input  logic                 issue_rs2_use_i,
   input  logic                 issue_wen_i,
   input  logic [IDX_W-1:0]     issue_rd_i,
   input  logic [NWB-1:0]       wb_valid_i,
   input  logic [NWB*IDX_W-1:0] wb_rd_i,
   input  logic                 clear_i,
   output logic                 stall_n_o,
   output logic                 issue_fire_o,
   output logic [NREG-1:0]      busy_o,
   output logic [OUT_W-1:0]     outstanding_o,
   output logic                 err_o
);

   localparam int unsigned DW = CNT_W + 1;
   localparam int unsigned SW = OUT_W + $clog2(NWB + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [OUT_W-1:0] out_q, out_d;
   logic             err_q, err_d;

   logic [DW-1:0]    dec_cnt [NREG];
   logic [NREG-1:0]  inc_vec;
   logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
   logic             rs1_stall, rs2_stall, sat_stall;
   logic             stall_n, fire;
`ifdef SB_BYPASS_EN
   logic             rs1_ret, rs2_ret, rd_ret;
`endif

   // Writeback hit count per register; index 0 never counts.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         dec_cnt[r] = '0;
         for (int unsigned k = 0; k < NWB; k++) begin
            if (r != 0 && wb_valid_i[k] && wb_rd_i[k*IDX_W +: IDX_W] == IDX_W'(r))
               dec_cnt[r] = dec_cnt[r] + DW'(1);
         end
      end
   end

   // Operand lookups leave x0 at zero, so x0 never stalls.
   always_comb begin
      rs1_cnt = '0;
      rs2_cnt = '0;
      rd_cnt  = '0;
`ifdef SB_BYPASS_EN
      rs1_ret = 1'b0;
      rs2_ret = 1'b0;
      rd_ret  = 1'b0;
`endif
      for (int unsigned r = 1; r < NREG; r++) begin
         if (issue_rs1_i == IDX_W'(r)) begin
            rs1_cnt = cnt_q[r];
`ifdef SB_BYPASS_EN
            rs1_ret = (dec_cnt[r] != '0);
`endif
         end
         if (issue_rs2_i == IDX_W'(r)) begin
            rs2_cnt = cnt_q[r];
`ifdef SB_BYPASS_EN
            rs2_ret = (dec_cnt[r] != '0);
`endif
         end
         if (issue_rd_i == IDX_W'(r)) begin
            rd_cnt = cnt_q[r];
`ifdef SB_BYPASS_EN
            rd_ret = (dec_cnt[r] != '0);
`endif
         end
      end
   end

   always_comb begin
`ifdef SB_BYPASS_EN
      rs1_stall = issue_rs1_use_i && rs1_cnt != '0 && !(rs1_cnt == CNT_W'(1) && rs1_ret);
      rs2_stall = issue_rs2_use_i && rs2_cnt != '0 && !(rs2_cnt == CNT_W'(1) && rs2_ret);
      sat_stall = issue_wen_i && rd_cnt == CNT_MAX && !rd_ret;
`else
      rs1_stall = issue_rs1_use_i && rs1_cnt != '0;
      rs2_stall = issue_rs2_use_i && rs2_cnt != '0;
      sat_stall = issue_wen_i && rd_cnt == CNT_MAX;
`endif
      stall_n = !(rs1_stall || rs2_stall || sat_stall || clear_i);
      fire    = issue_valid_i && stall_n;
   end

   always_comb begin
      inc_vec = '0;
      for (int unsigned r = 1; r < NREG; r++)
         inc_vec[r] = fire && issue_wen_i && (issue_rd_i == IDX_W'(r));
   end

   // Net +inc-dec per register in one edge; underflow clamps to 0 and flags an error.
   logic [DW-1:0] sum, diff;
   logic [SW-1:0] tot_inc, tot_dec, add, odiff;
   logic          under;

   always_comb begin
      sum     = '0;
      diff    = '0;
      tot_inc = '0;
      tot_dec = '0;
      under   = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         sum = {1'b0, cnt_q[r]} + DW'(inc_vec[r]);
         if (sum < dec_cnt[r]) begin
            under    = 1'b1;
            cnt_d[r] = '0;
            tot_dec  = tot_dec + SW'(sum);
         end else begin
            diff     = sum - dec_cnt[r];
            cnt_d[r] = (diff > DW'(CNT_MAX)) ? CNT_MAX : diff[CNT_W-1:0];
            tot_dec  = tot_dec + SW'(dec_cnt[r]);
         end
         tot_inc = tot_inc + SW'(inc_vec[r]);
      end

      add   = SW'(out_q) + tot_inc;
      odiff = '0;
      if (add < tot_dec) begin
         out_d = '0;
      end else begin
         odiff = add - tot_dec;
         out_d = (odiff > SW'(OUT_MAX)) ? OUT_MAX : odiff[OUT_W-1:0];
      end

      err_d = err_q || (under && !clear_i);

      if (clear_i) begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt_d[r] = '0;
         out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt_q[r] <= '0;
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt_q[r] <= cnt_d[r];
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++)
         busy_o[r] = (cnt_q[r] != '0);
   end

   assign stall_n_o     = stall_n;
   assign issue_fire_o  = fire;
   assign outstanding_o = out_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow SB_BYPASS_EN when defined.
module tb_reg_scoreboard;

   localparam int unsigned NREG  = 32;
   localparam int unsigned IDX_W = 5;
   localparam int unsigned NWB   = 2;
   localparam int unsigned OUT_W = 6;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 issue_valid;
   logic [IDX_W-1:0]     issue_rs1;
   logic                 issue_rs1_use;
   logic [IDX_W-1:0]     issue_rs2;
   logic                 issue_rs2_use;
   logic                 issue_wen;
   logic [IDX_W-1:0]     issue_rd;
   logic [NWB-1:0]       wb_valid;
   logic [NWB*IDX_W-1:0] wb_rd;
   logic                 clear;
   logic                 stall_n;
   logic                 fire;
   logic [NREG-1:0]      busy;
   logic [OUT_W-1:0]     outstanding;
   logic                 err;

   int total = 0;
   int bad   = 0;

`ifdef SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_scoreboard #(.NREG(NREG), .IDX_W(IDX_W), .NWB(NWB), .CNT_W(2), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid_i(issue_valid), .issue_rs1_i(issue_rs1), .issue_rs1_use_i(issue_rs1_use),
      .issue_rs2_i(issue_rs2), .issue_rs2_use_i(issue_rs2_use),
      .issue_wen_i(issue_wen), .issue_rd_i(issue_rd),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .clear_i(clear),
      .stall_n_o(stall_n), .issue_fire_o(fire), .busy_o(busy),
      .outstanding_o(outstanding), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_rs1 = '0; issue_rs1_use = 0; issue_rs2 = '0; issue_rs2_use = 0;
      issue_wen = 0; issue_rd = '0; wb_valid = '0; wb_rd = '0; clear = 0;
   endtask

   task automatic set_issue(input logic v, input int rs1, input logic u1, input int rs2,
                            input logic u2, input logic wen, input int rd);
      issue_valid = v; issue_rs1 = IDX_W'(rs1); issue_rs1_use = u1;
      issue_rs2 = IDX_W'(rs2); issue_rs2_use = u2; issue_wen = wen; issue_rd = IDX_W'(rd);
   endtask

   task automatic set_wb(input logic v0, input int rd0, input logic v1, input int rd1);
      wb_valid = {v1, v0};
      wb_rd = {IDX_W'(rd1), IDX_W'(rd0)};
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #3;
      total++; if (busy !== '0) begin $display("FAIL reset_busy: got %h want 0", busy); bad++; end
      total++; if (outstanding !== '0) begin $display("FAIL reset_out: got %0d want 0", outstanding); bad++; end
      total++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); bad++; end
      total++; if (stall_n !== 1'b1) begin $display("FAIL reset_stall_n: got %b want 1", stall_n); bad++; end
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_issue();
      set_issue(1, 0, 0, 0, 0, 1, 5);
      #1;
      total++; if (fire !== 1'b1) begin $display("FAIL issue_fire: got %b want 1", fire); bad++; end
      total++; if (busy[5] !== 1'b0) begin $display("FAIL issue_busy_early: got %b want 0", busy[5]); bad++; end
      tick();
      idle();
      #1;
      total++; if (busy !== 32'h0000_0020) begin $display("FAIL issue_busy: got %h want 00000020", busy); bad++; end
      total++; if (outstanding !== 6'd1) begin $display("FAIL issue_out: got %0d want 1", outstanding); bad++; end
   endtask

   task automatic test_raw_hazard();
      set_issue(1, 5, 1, 0, 0, 0, 0);
      #1;
      total++; if (stall_n !== 1'b0) begin $display("FAIL raw_stall: got %b want 0", stall_n); bad++; end
      total++; if (fire !== 1'b0) begin $display("FAIL raw_fire: got %b want 0", fire); bad++; end
      tick();
      total++; if (stall_n !== 1'b0) begin $display("FAIL raw_stall_hold: got %b want 0", stall_n); bad++; end
      set_wb(1, 5, 0, 0);
      #1;
      total++; if (stall_n !== BYP) begin $display("FAIL raw_wb_cycle: got %b want %b", stall_n, BYP); bad++; end
      tick();
      set_wb(0, 0, 0, 0);
      #1;
      total++; if (stall_n !== 1'b1) begin $display("FAIL raw_release: got %b want 1", stall_n); bad++; end
      total++; if (busy[5] !== 1'b0) begin $display("FAIL raw_busy_clear: got %b want 0", busy[5]); bad++; end
      tick();
      idle();
      #1;
      total++; if (outstanding !== 6'd0) begin $display("FAIL raw_out: got %0d want 0", outstanding); bad++; end
   endtask

   task automatic test_saturation();
      set_issue(1, 0, 0, 0, 0, 1, 7);
      tick(); tick(); tick();
      #1;
      total++; if (outstanding !== 6'd3) begin $display("FAIL sat_out3: got %0d want 3", outstanding); bad++; end
      total++; if (stall_n !== 1'b0) begin $display("FAIL sat_stall: got %b want 0", stall_n); bad++; end
      tick();
      total++; if (outstanding !== 6'd3) begin $display("FAIL sat_hold: got %0d want 3", outstanding); bad++; end
      set_wb(0, 0, 1, 7);
      #1;
      total++; if (fire !== BYP) begin $display("FAIL sat_wb_fire: got %b want %b", fire, BYP); bad++; end
      tick();
      set_wb(0, 0, 0, 0);
      if (!BYP) begin
         #1;
         total++; if (outstanding !== 6'd2) begin $display("FAIL sat_after_retire: got %0d want 2", outstanding); bad++; end
         total++; if (fire !== 1'b1) begin $display("FAIL sat_accept: got %b want 1", fire); bad++; end
         tick();
      end
      idle();
      #1;
      total++; if (outstanding !== 6'd3) begin $display("FAIL sat_out_final: got %0d want 3", outstanding); bad++; end
      set_wb(1, 7, 1, 7);
      tick();
      set_wb(1, 7, 0, 0);
      tick();
      idle();
      #1;
      total++; if (busy !== '0 || outstanding !== 6'd0)
         begin $display("FAIL sat_drain: busy=%h out=%0d want 0/0", busy, outstanding); bad++; end
   endtask

   task automatic test_multi_retire();
      set_issue(1, 0, 0, 0, 0, 1, 9);
      tick(); tick();
      set_wb(1, 9, 1, 9);
      #1;
      total++; if (fire !== 1'b1) begin $display("FAIL multi_fire: got %b want 1", fire); bad++; end
      tick();
      idle();
      #1;
      total++; if (outstanding !== 6'd1) begin $display("FAIL multi_out: got %0d want 1", outstanding); bad++; end
      total++; if (busy !== 32'h0000_0200) begin $display("FAIL multi_busy: got %h want 00000200", busy); bad++; end
      set_issue(1, 0, 0, 0, 0, 1, 11);
      tick();
      set_wb(1, 11, 0, 0);
      tick();
      idle();
      #1;
      total++; if (outstanding !== 6'd2) begin $display("FAIL same_cycle_out: got %0d want 2", outstanding); bad++; end
      total++; if (busy !== 32'h0000_0A00) begin $display("FAIL same_cycle_busy: got %h want 00000a00", busy); bad++; end
      set_wb(1, 9, 1, 11);
      tick();
      idle();
      #1;
      total++; if (outstanding !== 6'd0) begin $display("FAIL multi_drain: got %0d want 0", outstanding); bad++; end
   endtask

   task automatic test_x0();
      set_issue(1, 0, 1, 0, 1, 1, 0);
      #1;
      total++; if (fire !== 1'b1) begin $display("FAIL x0_fire: got %b want 1", fire); bad++; end
      tick();
      idle();
      #1;
      total++; if (busy !== '0 || outstanding !== 6'd0)
         begin $display("FAIL x0_untracked: busy=%h out=%0d want 0/0", busy, outstanding); bad++; end
      set_wb(1, 0, 1, 0);
      tick();
      idle();
      #1;
      total++; if (err !== 1'b0) begin $display("FAIL x0_wb_err: got %b want 0", err); bad++; end
   endtask

   task automatic test_underflow();
      set_wb(1, 12, 0, 0);
      tick();
      idle();
      #1;
      total++; if (err !== 1'b1) begin $display("FAIL under_err: got %b want 1", err); bad++; end
      total++; if (busy[12] !== 1'b0 || outstanding !== 6'd0)
         begin $display("FAIL under_cnt: busy12=%b out=%0d want 0/0", busy[12], outstanding); bad++; end
      tick(); tick();
      total++; if (err !== 1'b1) begin $display("FAIL under_sticky: got %b want 1", err); bad++; end
   endtask

   task automatic test_clear();
      set_issue(1, 0, 0, 0, 0, 1, 1); tick();
      set_issue(1, 0, 0, 0, 0, 1, 2); tick();
      set_issue(1, 0, 0, 0, 0, 1, 3); tick();
      idle();
      #1;
      total++; if (busy !== 32'h0000_000E) begin $display("FAIL clear_pre_busy: got %h want 0000000e", busy); bad++; end
      set_issue(1, 0, 0, 0, 0, 1, 4);
      clear = 1;
      #1;
      total++; if (stall_n !== 1'b0) begin $display("FAIL clear_stall: got %b want 0", stall_n); bad++; end
      total++; if (fire !== 1'b0) begin $display("FAIL clear_fire: got %b want 0", fire); bad++; end
      tick();
      idle();
      #1;
      total++; if (busy !== '0) begin $display("FAIL clear_busy: got %h want 0", busy); bad++; end
      total++; if (outstanding !== 6'd0) begin $display("FAIL clear_out: got %0d want 0", outstanding); bad++; end
      total++; if (err !== 1'b1) begin $display("FAIL clear_err_kept: got %b want 1", err); bad++; end
   endtask

   task automatic test_async_reset();
      set_issue(1, 0, 0, 0, 0, 1, 6);
      tick();
      idle();
      #1;
      total++; if (busy[6] !== 1'b1) begin $display("FAIL areset_pre: got %b want 1", busy[6]); bad++; end
      #1;
      rst_n = 0;
      #1;
      total++; if (busy !== '0 || outstanding !== 6'd0 || err !== 1'b0)
         begin $display("FAIL areset_now: busy=%h out=%0d err=%b want 0/0/0", busy, outstanding, err); bad++; end
      #1;
      rst_n = 1;
      tick();
      set_issue(1, 6, 1, 0, 0, 0, 0);
      #1;
      total++; if (stall_n !== 1'b1) begin $display("FAIL areset_no_pending: got %b want 1", stall_n); bad++; end
      idle();
   endtask

   initial begin
      test_reset();
      test_issue();
      test_raw_hazard();
      test_saturation();
      test_multi_retire();
      test_x0();
      test_underflow();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised register-hazard scoreboard for the in-order pipeline. It replaces the fixed two-instruction hazard compare with per-register pending-write counters, so any number of writes can be in flight, including from multi-cycle units. The block sits beside the decode stage: issue is checked against the counters, and writeback ports decrement them. It drives the decode/PC stall and reports busy state for debug and difftest.

Parameters:
NREG, 32, number of architectural registers tracked.
IDX_W, 5, register index width; must satisfy 2^IDX_W >= NREG.
NWB, 2, number of independent writeback/retire ports.
CNT_W, 2, pending counter width; maximum outstanding writes per register = 2^CNT_W-1.
OUT_W, 6, width of the total-outstanding counter.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
issue_valid_i  in  1  decode stage presents an instruction
issue_rs1_i  in  IDX_W  source 1 index
issue_rs1_use_i  in  1  source 1 is read
issue_rs2_i  in  IDX_W  source 2 index
issue_rs2_use_i  in  1  source 2 is read
issue_wen_i  in  1  instruction writes rd
issue_rd_i  in  IDX_W  destination index
wb_valid_i  in  NWB  per-port retire strobe; squashed instructions also retire
wb_rd_i  in  NWB*IDX_W  per-port rd, port k at [k*IDX_W +: IDX_W]
clear_i  in  1  synchronous clear of all counters after pipeline drain
stall_n_o  out  1  low = hold PC/ID, issue not accepted
issue_fire_o  out  1  issue_valid_i & stall_n_o
busy_o  out  NREG  bit r = counter[r] != 0
outstanding_o  out  OUT_W  total pending writes, all registers
err_o  out  1  sticky: decrement of a zero counter

Behaviour:
- Decided interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all counters 0, outstanding_o=0, err_o=0. Resulting outputs: busy_o=0, stall_n_o=1.
- Register 0 is never tracked. Reads of x0 never stall. Writes to x0 never increment or decrement. wb_rd=0 is ignored and raises no error.
- stall_n_o is combinational and goes low when any of the following holds:
  - issue_rs1_use_i & rs1!=0 & counter[rs1]!=0
  - the same condition for rs2
  - issue_wen_i & rd!=0 & counter[rd] saturated at 2^CNT_W-1
  - clear_i
- stall_n_o is independent of issue_valid_i.
- Issue accepted: issue_fire_o. On acceptance with wen and rd!=0, counter[rd] increments next edge.
- Writeback: each valid port k with rd!=0 decrements counter[rd_k].
  - Multiple ports naming the same rd decrement by the number of hits.
  - Net update per register = +inc - dec, applied in a single edge. Arithmetic is in CNT_W+1 bits.
  - If the net result would go below 0, the counter is held at 0 and err_o sets. err_o is cleared only by reset.
- Simultaneous issue and writeback to the same rd: net change, e.g. count 1 with one inc and one dec stays 1.
- outstanding_o = registered sum of counters, updated with the same net rule. It saturates at 2^OUT_W-1.
- clear_i: all counters and outstanding_o go to 0 next edge. Issue and writebacks in that cycle are discarded. err_o is unaffected.
- Reset asserted mid-operation: immediate return to reset values, no pending state retained.
- Latency: issue to busy visible = 1 cycle. Writeback to stall release = 1 cycle (0 cycles with the optional feature).

Optional Feature:
SB_BYPASS_EN
- Defined: a source hit on register r does not stall if counter[r]==1 and some wb port retires r in the same cycle. This lets forwarding from WB supply the operand.
- Saturation stall likewise lifts if a same-cycle retire of rd exists.
- Undefined: the stall is based on registered counters only, giving one extra bubble.

Test Plan:
1. Reset, then issue rd=5 wen with no sources -> issue_fire_o=1; next cycle busy_o[5]=1, outstanding_o=1.
2. With x5 pending, issue rs1=5 use -> stall_n_o=0 until wb_valid_i[0]=1, wb_rd=5; the cycle after, stall_n_o=1 (with SB_BYPASS_EN: stall_n_o=1 in the wb cycle itself).
3. CNT_W=2: three issues to rd=7 -> counter 3; fourth issue to rd=7 -> stall_n_o=0; one retire of 7 -> fourth is accepted next cycle.
4. Counter[9]=2; both wb ports retire 9 in the same cycle while an issue of rd=9 fires -> counter[9]=1, outstanding_o drops by 1.
5. Retire rd=12 with counter 0 -> err_o=1 and stays 1, counter 0; retire rd=0 -> no error.
6. Three pending registers, pulse clear_i with a concurrent issue -> stall_n_o=0 that cycle; next cycle busy_o=0, outstanding_o=0, the issue is not recorded.
